complex_mult_initiator: RTL

RTL initiator for the complex multiplier operand/result handshake. It buffers operand sets from a host stream in a small FIFO and issues them on the op_val/op_ready interface. It accepts results on res_val/res_ready and re-presents them to the host through a one-entry output register. It sits between host logic and complex_nr_mult_1, replacing the bench-only stimulus driver in the synthesizable design.

---
 rtl/complex_mult_pkg.sv | 18 +
 rtl/cplx_op_fifo.sv | 51 +++++
 rtl/complex_mult_initiator.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/complex_mult_pkg.sv
// Shared types and constants for the complex multiplier initiator slice.
package complex_mult_pkg;
    localparam int OUTSTANDING_W      = 4;
    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic [DEFAULT_DATA_WIDTH-1:0] op_1_re;
        logic [DEFAULT_DATA_WIDTH-1:0] op_1_im;
        logic [DEFAULT_DATA_WIDTH-1:0] op_2_re;
        logic [DEFAULT_DATA_WIDTH-1:0] op_2_im;
    } operand_set_t;
endpackage

// File: rtl/cplx_op_fifo.sv
// Operand-set FIFO: registered storage, head visible combinationally, reads 0 when empty.
module cplx_op_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // The extra count bit tells full from empty when the pointers meet.
    assign full    = (count == (PTR_W + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rstn || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/complex_mult_initiator.sv
// Buffers host operand sets, issues them to the complex multiplier and re-presents results.
// Optional watchdog output timeout_err is built when CPLX_INIT_TIMEOUT_EN is defined.
module complex_mult_initiator
    import complex_mult_pkg::*;
#(
    parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     sw_rst,
    input  logic                     flush,
    input  logic                     in_val,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_op_1_re,
    input  logic [DATA_WIDTH-1:0]    in_op_1_im,
    input  logic [DATA_WIDTH-1:0]    in_op_2_re,
    input  logic [DATA_WIDTH-1:0]    in_op_2_im,
    output logic                     op_val,
    input  logic                     op_ready,
    output logic [DATA_WIDTH-1:0]    op_1_re,
    output logic [DATA_WIDTH-1:0]    op_1_im,
    output logic [DATA_WIDTH-1:0]    op_2_re,
    output logic [DATA_WIDTH-1:0]    op_2_im,
    input  logic                     res_val,
    output logic                     res_ready,
    input  logic [2*DATA_WIDTH-1:0]  result_re,
    input  logic [2*DATA_WIDTH-1:0]  result_im,
    output logic                     out_val,
    input  logic                     out_ready,
    output logic [2*DATA_WIDTH-1:0]  out_re,
    output logic [2*DATA_WIDTH-1:0]  out_im,
    output logic [OUTSTANDING_W-1:0] outstanding,
    output logic                     flush_done,
    output logic                     busy,
    output state_t                   fsm_state
`ifdef CPLX_INIT_TIMEOUT_EN
    ,
    output logic                     timeout_err
`endif
);
    // Handshakes: a transfer happens on the rising edge where valid && ready are both high;
    // valid never depends on ready, and payload holds while valid && !ready.

    // A bad parameter set keeps the initiator from ever issuing.
    localparam logic PARAMS_OK = (FIFO_DEPTH >= 2) && (MAX_OUTSTANDING >= 1) &&
                                 (MAX_OUTSTANDING <= 15) && (TIMEOUT_CYCLES >= 1);

    state_t                  state;
    state_t                  state_nxt;
    logic                    soft_rst;
    logic                    push;
    logic                    issue;
    logic                    cap_ok;
    logic                    flush_exit;
    logic                    full;
    logic                    empty;
    logic [4*DATA_WIDTH-1:0] head;

    assign soft_rst  = !rstn || sw_rst;
    assign in_ready  = !full && (state != FLUSH);
    assign push      = in_val && in_ready;
    assign op_val    = PARAMS_OK && !empty && (state != FLUSH) &&
                       (outstanding < OUTSTANDING_W'(MAX_OUTSTANDING));
    assign issue     = op_val && op_ready;
    assign res_ready = !out_val || out_ready;
    // A result with nothing outstanding is a protocol error and is dropped.
    assign cap_ok    = res_val && res_ready && (outstanding != '0);
    assign busy      = (state != IDLE);
    assign fsm_state = state;

    assign {op_1_re, op_1_im, op_2_re, op_2_im} = head;

    cplx_op_fifo #(
        .WIDTH (4 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (sw_rst || flush_exit),
        .push    (push),
        .pop     (issue),
        .wr_data ({in_op_1_re, in_op_1_im, in_op_2_re, in_op_2_im}),
        .rd_data (head),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        state_nxt  = state;
        flush_exit = 1'b0;
        case (state)
            IDLE: begin
                if (flush)     state_nxt = FLUSH;
                else if (push) state_nxt = RUN;
            end
            RUN: begin
                if (flush)
                    state_nxt = FLUSH;
                else if (empty && !push && (outstanding == '0) && !out_val)
                    state_nxt = IDLE;
            end
            FLUSH: begin
                if ((outstanding == '0) && !out_val) begin
                    state_nxt  = IDLE;
                    flush_exit = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (soft_rst) begin
            state       <= IDLE;
            outstanding <= '0;
            out_val     <= 1'b0;
            out_re      <= '0;
            out_im      <= '0;
            flush_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_done <= flush_exit;
            if (cap_ok) begin
                out_val <= 1'b1;
                out_re  <= result_re;
                out_im  <= result_im;
            end else if (out_ready) begin
                out_val <= 1'b0;
            end
            case ({issue, cap_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef CPLX_INIT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wd_cnt;

    // Counts idle cycles while work is in flight; the error flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (soft_rst) begin
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
        end else if (cap_ok || (outstanding == '0)) begin
            wd_cnt <= '0;
        end else if (wd_cnt != TO_W'(TIMEOUT_CYCLES)) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
        end
    end
`endif
endmodule
